// File: rtl/oc_ram_copy_master.sv
// Avalon-MM initiator that copies a word range inside the on-chip RAM or fills it with a pattern.
// Optional build macro CHECKSUM_EN adds a mod-2^32 accumulator of all written words.
module oc_ram_copy_master #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 5120
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [31:0]       fill_pattern,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_done,
    output logic [31:0]       checksum,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state_r;
    logic              mode_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [31:0]       pat_r;
    logic [31:0]       wdata_r;
    logic [ADDR_W-1:0] addr_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              cs_r;
    logic              wr_r;

    logic [ADDR_W-1:0] next_cnt_s;
    logic [ADDR_W:0]   src_end_s;
    logic [ADDR_W:0]   dst_end_s;
    logic              range_err_s;
    logic [31:0]       wdata_s;

    // Range checks on the live operands and the data for the current write
    always_comb begin
        next_cnt_s  = cnt_r + ADDR_W'(1);
        src_end_s   = {1'b0, src_addr} + {1'b0, length};
        dst_end_s   = {1'b0, dst_addr} + {1'b0, length};
        range_err_s = ((mode == 1'b0) && (src_end_s > DEPTH_L)) || (dst_end_s > DEPTH_L);
        if (mode_r) begin
            wdata_s = pat_r;
        end else begin
            wdata_s = m_readdata;
        end
    end

    // Control FSM with registered bus and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            mode_r  <= 1'b0;
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
            pat_r   <= 32'h0;
            wdata_r <= 32'h0;
            addr_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            cs_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        src_r   <= src_addr;
                        dst_r   <= dst_addr;
                        len_r   <= length;
                        pat_r   <= fill_pattern;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        if (length == '0) begin
                            error_r <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else if (range_err_s) begin
                            error_r <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else if (mode) begin
                            error_r <= 1'b0;
                            cs_r    <= 1'b1;
                            wr_r    <= 1'b1;
                            addr_r  <= dst_addr;
                            state_r <= WR;
                        end else begin
                            error_r <= 1'b0;
                            cs_r    <= 1'b1;
                            wr_r    <= 1'b0;
                            addr_r  <= src_addr;
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (abort) begin
                        cs_r    <= 1'b0;
                        wr_r    <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        wr_r    <= 1'b1;
                        addr_r  <= dst_r + cnt_r;
                        state_r <= WR;
                    end
                end
                WR: begin
                    cnt_r   <= next_cnt_s;
                    wdata_r <= wdata_s;
                    if ((next_cnt_s == len_r) || abort) begin
                        cs_r    <= 1'b0;
                        wr_r    <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (mode_r) begin
                        addr_r  <= dst_r + next_cnt_s;
                        state_r <= WR;
                    end else begin
                        wr_r    <= 1'b0;
                        addr_r  <= src_r + next_cnt_s;
                        state_r <= RD;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cs_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic [31:0] sum_r;

    // Running sum of written words, cleared by each accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= 32'h0;
        end else if ((state_r == IDLE) && start) begin
            sum_r <= 32'h0;
        end else if (state_r == WR) begin
            sum_r <= sum_r + wdata_s;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign checksum = sum_r;
`else
    assign checksum = 32'h0;
`endif

    // In copy mode the read data flows straight through to the write port
    assign m_writedata  = ((state_r == WR) && !mode_r) ? m_readdata : ((state_r == WR) ? pat_r : wdata_r);
    assign m_address    = addr_r;
    assign m_chipselect = cs_r;
    assign m_write      = wr_r;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_done   = cnt_r;

endmodule
